// File: rtl/sw_debounce_if.sv
// ----------------------------------------------------------------------------
// sw_debounce_if
// Groups the switch-conditioning signals into one bundle.
//   i_sw      raw switch pins (asynchronous to the debouncer clock)
//   o_sw      debounced switch level
//   o_rise    one-cycle pulse per bit on a settled 0->1 transition
//   o_fall    one-cycle pulse per bit on a settled 1->0 transition
//   o_change  one-cycle pulse when any bit rises or falls
// Modports:
//   master : the switch source / consumer side (drives i_sw, reads results)
//   slave  : the debouncer itself (reads i_sw, drives results)
// ----------------------------------------------------------------------------
interface sw_debounce_if #(
  parameter int NB_SW = 4
);
  logic [NB_SW-1:0] i_sw;
  logic [NB_SW-1:0] o_sw;
  logic [NB_SW-1:0] o_rise;
  logic [NB_SW-1:0] o_fall;
  logic             o_change;

  modport master (
    output i_sw,
    input  o_sw,
    input  o_rise,
    input  o_fall,
    input  o_change
  );

  modport slave (
    input  i_sw,
    output o_sw,
    output o_rise,
    output o_fall,
    output o_change
  );
endinterface

// File: rtl/sw_debounce.sv
// ----------------------------------------------------------------------------
// sw_debounce
// Synchronises each raw switch bit into the clock domain and rejects contact
// bounce with a per-bit stability counter. The debounced level only flips
// after DEB_COUNT consecutive cycles in which the synchronised input differs
// from it; any return to the current level discards the partial count.
// Ports:
//   clock    single clock, all state on its rising edge
//   i_reset  asynchronous active-low reset, clears all state
//   bus      sw_debounce_if.slave: i_sw in, o_sw/o_rise/o_fall/o_change out
// Parameters:
//   NB_SW      number of independent switch bits
//   NB_DEB     width of each stability counter
//   DEB_COUNT  mismatch cycles needed to flip (2 .. 2**NB_DEB)
// All outputs are flop-driven; nothing combinational reaches them from i_sw.
// ----------------------------------------------------------------------------
module sw_debounce #(
  parameter int NB_SW     = 4,
  parameter int NB_DEB    = 16,
  parameter int DEB_COUNT = 50000
) (
  input  logic          clock,
  input  logic          i_reset,
  sw_debounce_if.slave  bus
);

  // Terminal count: DEB_COUNT-1 always fits in NB_DEB bits for the legal range.
  localparam logic [NB_DEB-1:0] CNT_LAST = NB_DEB'(DEB_COUNT - 1);

  logic [NB_SW-1:0]  sync1;
  logic [NB_SW-1:0]  sync2;
  logic [NB_SW-1:0]  sw_level;
  logic [NB_SW-1:0]  rise_pulse;
  logic [NB_SW-1:0]  fall_pulse;
  logic              change_pulse;
  logic [NB_SW-1:0]  flip;
  logic [NB_DEB-1:0] cnt      [NB_SW];
  logic [NB_DEB-1:0] cnt_next [NB_SW];

  // Per-bit stability logic. A flip happens on the edge where a mismatch is
  // seen with the counter already at its terminal value; the counter then
  // restarts from zero, as it does whenever the input agrees with the level.
  generate
    for (genvar gi = 0; gi < NB_SW; gi++) begin : g_bit
      logic mismatch;

      assign mismatch      = sync2[gi] ^ sw_level[gi];
      assign flip[gi]      = mismatch && (cnt[gi] == CNT_LAST);
      assign cnt_next[gi]  = (mismatch && !flip[gi]) ? cnt[gi] + NB_DEB'(1)
                                                     : '0;
    end
  endgenerate

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1        <= '0;
      sync2        <= '0;
      sw_level     <= '0;
      rise_pulse   <= '0;
      fall_pulse   <= '0;
      change_pulse <= 1'b0;
      for (int i = 0; i < NB_SW; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1        <= bus.i_sw;
      sync2        <= sync1;
      // A flipping bit always takes the synchronised value, which is the
      // inverse of its current level, so toggling is equivalent.
      sw_level     <= sw_level ^ flip;
      // Pulses are rebuilt every cycle, so they can never last two cycles.
      rise_pulse   <= flip & sync2;
      fall_pulse   <= flip & ~sync2;
      change_pulse <= |flip;
      for (int i = 0; i < NB_SW; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign bus.o_sw     = sw_level;
  assign bus.o_rise   = rise_pulse;
  assign bus.o_fall   = fall_pulse;
  assign bus.o_change = change_pulse;

endmodule

// File: tb/tb_sw_debounce.sv
// ----------------------------------------------------------------------------
// tb_sw_debounce
// Self-checking bench for sw_debounce with NB_SW=4, NB_DEB=4, DEB_COUNT=4.
// Directed scenarios check fixed expectations; a randomised run compares the
// DUT every cycle with a reference model that keeps a sliding window of the
// last DEB_COUNT synchronised samples and flips a bit when all of them
// disagree with its current debounced level.
// ----------------------------------------------------------------------------
module tb_sw_debounce;
  localparam int NB_SW     = 4;
  localparam int NB_DEB    = 4;
  localparam int DEB_COUNT = 4;

  logic clock   = 1'b0;
  logic i_reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  sw_debounce_if #(.NB_SW(NB_SW)) bus ();

  sw_debounce #(
    .NB_SW     (NB_SW),
    .NB_DEB    (NB_DEB),
    .DEB_COUNT (DEB_COUNT)
  ) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // ---------------- reference model ----------------
  logic [NB_SW-1:0] m_s1, m_s2, m_sw, m_rise, m_fall;
  logic             m_change;
  logic [NB_SW-1:0] m_win[$];

  always @(posedge clock or negedge i_reset) begin : model
    logic [NB_SW-1:0] flip;
    bit all_diff;
    if (!i_reset) begin
      m_s1 = '0; m_s2 = '0; m_sw = '0;
      m_rise = '0; m_fall = '0; m_change = 1'b0;
      m_win.delete();
    end else begin
      m_win.push_back(m_s2);
      if (m_win.size() > DEB_COUNT) void'(m_win.pop_front());
      flip = '0;
      if (m_win.size() == DEB_COUNT) begin
        for (int b = 0; b < NB_SW; b++) begin
          all_diff = 1'b1;
          foreach (m_win[k]) if (m_win[k][b] == m_sw[b]) all_diff = 1'b0;
          flip[b] = all_diff;
        end
      end
      m_rise   = flip & ~m_sw;
      m_fall   = flip & m_sw;
      m_change = |flip;
      m_sw     = m_sw ^ flip;
      m_s2     = m_s1;
      m_s1     = bus.i_sw;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_reset  = 1'b0;
    bus.i_sw = 4'hF;
    cyc(3);
    checks++;
    if ({bus.o_sw, bus.o_rise, bus.o_fall, bus.o_change} !== 13'h0) begin
      failures++;
      $display("FAIL reset_hold: got %h expected 0",
               {bus.o_sw, bus.o_rise, bus.o_fall, bus.o_change});
    end
    i_reset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clock);
      checks++;
      if (bus.o_sw !== ((e < 6) ? 4'h0 : 4'hF)) begin
        failures++;
        $display("FAIL reset_release_sw edge%0d: got %h expected %h",
                 e, bus.o_sw, (e < 6) ? 4'h0 : 4'hF);
      end
      checks++;
      if ({bus.o_rise, bus.o_change} !== ((e == 6) ? 5'h1F : 5'h00)) begin
        failures++;
        $display("FAIL reset_release_rise edge%0d: got %h expected %h",
                 e, {bus.o_rise, bus.o_change}, (e == 6) ? 5'h1F : 5'h00);
      end
      checks++;
      if (bus.o_fall !== 4'h0) begin
        failures++;
        $display("FAIL reset_release_fall edge%0d: got %h expected 0", e, bus.o_fall);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_glitch();
    i_reset  = 1'b0;
    bus.i_sw = 4'h0;
    cyc(2);
    i_reset = 1'b1;
    cyc(2);
    bus.i_sw = 4'h1;
    for (int e = 1; e <= 13; e++) begin
      @(negedge clock);
      checks++;
      if ({bus.o_sw, bus.o_rise, bus.o_fall, bus.o_change} !== 13'h0) begin
        failures++;
        $display("FAIL glitch edge%0d: got %h expected 0", e,
                 {bus.o_sw, bus.o_rise, bus.o_fall, bus.o_change});
      end
      if (e == 3) bus.i_sw = 4'h0;
    end
    $display("test_glitch done");
  endtask

  task automatic test_bounce();
    int rises = 0;
    for (int k = 0; k < 12; k++) begin
      bus.i_sw = (((k / 2) % 2) == 0) ? 4'h1 : 4'h0;
      @(negedge clock);
      rises += int'(bus.o_rise[0]);
      checks++;
      if ({bus.o_sw, bus.o_fall} !== 8'h0) begin
        failures++;
        $display("FAIL bounce_phase k%0d: got %h expected 0", k, {bus.o_sw, bus.o_fall});
      end
    end
    bus.i_sw = 4'h1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clock);
      rises += int'(bus.o_rise[0]);
      checks++;
      if ({bus.o_sw, bus.o_rise} !== ((e < 6) ? 8'h00 : (e == 6) ? 8'h11 : 8'h10)) begin
        failures++;
        $display("FAIL bounce_settle edge%0d: got %h expected %h", e,
                 {bus.o_sw, bus.o_rise}, (e < 6) ? 8'h00 : (e == 6) ? 8'h11 : 8'h10);
      end
      checks++;
      if (bus.o_fall !== 4'h0) begin
        failures++;
        $display("FAIL bounce_fall edge%0d: got %h expected 0", e, bus.o_fall);
      end
    end
    checks++;
    if (rises != 1) begin
      failures++;
      $display("FAIL bounce_rise_count: got %0d expected 1", rises);
    end
    $display("test_bounce done");
  endtask

  task automatic test_simultaneous();
    int changes = 0;
    bus.i_sw = 4'b0100;
    cyc(10);
    checks++;
    if (bus.o_sw !== 4'b0100) begin
      failures++;
      $display("FAIL simul_setup: got %h expected 4", bus.o_sw);
    end
    bus.i_sw = 4'b0010;
    for (int e = 1; e <= 8; e++) begin
      logic [12:0] want;
      @(negedge clock);
      changes += int'(bus.o_change);
      if (e < 6)       want = {4'b0100, 4'b0000, 4'b0000, 1'b0};
      else if (e == 6) want = {4'b0010, 4'b0010, 4'b0100, 1'b1};
      else             want = {4'b0010, 4'b0000, 4'b0000, 1'b0};
      checks++;
      if ({bus.o_sw, bus.o_rise, bus.o_fall, bus.o_change} !== want) begin
        failures++;
        $display("FAIL simul edge%0d: got %h expected %h", e,
                 {bus.o_sw, bus.o_rise, bus.o_fall, bus.o_change}, want);
      end
    end
    checks++;
    if (changes != 1) begin
      failures++;
      $display("FAIL simul_change_count: got %0d expected 1", changes);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid();
    bus.i_sw = 4'b0011;
    cyc(4);            // counter for bit 0 has reached 2 after the 4th edge
    #1 i_reset = 1'b0;
    #1;
    checks++;
    if ({bus.o_sw, bus.o_rise, bus.o_fall, bus.o_change} !== 13'h0) begin
      failures++;
      $display("FAIL reset_mid_async: got %h expected 0",
               {bus.o_sw, bus.o_rise, bus.o_fall, bus.o_change});
    end
    @(negedge clock);
    i_reset = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clock);
      checks++;
      if ({bus.o_sw, bus.o_rise} !== ((e < 6) ? 8'h00 : (e == 6) ? 8'h33 : 8'h30)) begin
        failures++;
        $display("FAIL reset_mid_restart edge%0d: got %h expected %h", e,
                 {bus.o_sw, bus.o_rise}, (e < 6) ? 8'h00 : (e == 6) ? 8'h33 : 8'h30);
      end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_boundary();
    i_reset  = 1'b0;
    bus.i_sw = 4'h0;
    cyc(1);
    i_reset = 1'b1;
    cyc(2);
    bus.i_sw = 4'h8;
    for (int e = 1; e <= 12; e++) begin
      logic [11:0] want;
      @(negedge clock);
      want[11:8] = (e >= 6 && e < 10) ? 4'h8 : 4'h0;
      want[7:4]  = (e == 6)  ? 4'h8 : 4'h0;
      want[3:0]  = (e == 10) ? 4'h8 : 4'h0;
      checks++;
      if ({bus.o_sw, bus.o_rise, bus.o_fall} !== want) begin
        failures++;
        $display("FAIL boundary edge%0d: got %h expected %h", e,
                 {bus.o_sw, bus.o_rise, bus.o_fall}, want);
      end
      if (e == 4) bus.i_sw = 4'h0;
    end
    $display("test_boundary done");
  endtask

  task automatic test_random();
    int hold [NB_SW];
    int errs = 0;
    for (int b = 0; b < NB_SW; b++) hold[b] = 1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      checks++;
      if ({bus.o_sw, bus.o_rise, bus.o_fall, bus.o_change} !==
          {m_sw, m_rise, m_fall, m_change}) begin
        failures++;
        errs++;
        $display("FAIL random cycle%0d: got %h expected %h", c,
                 {bus.o_sw, bus.o_rise, bus.o_fall, bus.o_change},
                 {m_sw, m_rise, m_fall, m_change});
      end
      if ($urandom_range(0, 199) == 0) begin
        #1 i_reset = 1'b0;
        #1;
        checks++;
        if ({bus.o_sw, bus.o_rise, bus.o_fall, bus.o_change} !== 13'h0) begin
          failures++;
          $display("FAIL random_reset cycle%0d: got %h expected 0", c,
                   {bus.o_sw, bus.o_rise, bus.o_fall, bus.o_change});
        end
        @(negedge clock);
        i_reset = 1'b1;
      end
      for (int b = 0; b < NB_SW; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          bus.i_sw[b] = ~bus.i_sw[b];
          hold[b] = int'($urandom_range(1, 7));
        end
      end
    end
    $display("test_random done mismatches=%0d", errs);
  endtask

  initial begin
    bus.i_sw = '0;
    test_reset();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
